// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the access-size and FSM encodings, the control bundle with its bubble
// value, the EX/MEM and MEM/WB latch layouts and the alignment check.
//
// Bit numbering note: the architecture numbers bits big-endian, with bit 0 as
// the MSB. The RTL uses conventional [31:0] vectors. Architectural bits
// [30:31] are therefore [1:0] here. Byte offset 0 (bits [0:7]) is
// data[31:24], and its byte enable is be[3].
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11   // decoded exactly like SZ_WORD
    } dsize_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic pc_to_reg;
        logic load_sign;
        logic fp_reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_val;
        logic [31:0] next_pc;
        logic [4:0]  dest_reg;
        logic [4:0]  f_dest_reg;
        logic [63:0] fbus_w;
        dsize_t      size;
        ctrl_t       ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [31:0] next_pc;
        logic [4:0]  dest_reg;
        logic [4:0]  f_dest_reg;
        logic [63:0] fbus_w;
        logic        reg_write;
        logic        mem_to_reg;
        logic        pc_to_reg;
        logic        fp_reg_write;
    } mem_wb_t;

    // Halfwords need an even address. Words need a 4-byte aligned address.
    function automatic logic is_misaligned(dsize_t size, logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the memory (slave).
//   dmem_addr  : word-aligned address        dmem_wdata : lane-steered store data
//   dmem_be    : byte enables, be[3]=MSB lane dmem_req/we: request and write strobe
//   dmem_rdata : read data                    dmem_ready : access complete
interface mem_stage_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_addr, dmem_wdata, dmem_be, dmem_req, dmem_we,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_be, dmem_req, dmem_we,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte or halfword lane of a
// big-endian read word. It right-justifies the lane, then sign- or zero-extends it.
//   rdata_i  : raw read word       offset_i : byte offset within the word
//   size_i   : access size         sign_i   : 1 = sign-extend
//   data_o   : aligned load result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  dsize_t      size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every always_comb output gets a value on every path (defaults or a
    // full case with default), otherwise synthesis infers a latch.
    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = rdata_i[31:24];
            2'd1:    byte_lane = rdata_i[23:16];
            2'd2:    byte_lane = rdata_i[15:8];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_o = {{16{sign_i & half_lane[15]}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. It latches EX results and performs data-memory loads and
// stores over a req/ready handshake. It presents a registered MEM/WB bundle to
// writeback.
//   clk, reset          : clock, asynchronous active-low reset
//   *_in (EX side)      : EX results and control, ex_stall_in inserts bubbles
//   dmem (master)       : data-memory bus
//   *_out (WB side)     : registered writeback bundle
//   stall_out           : freezes upstream while an access is outstanding
//   misalign_out        : one-cycle pulse, misaligned access dropped
//   bus_err_out         : one-cycle pulse, access aborted after TIMEOUT request cycles
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] memVal_in,
    input  logic [31:0] nextPC_in,
    input  logic [4:0]  destReg_in,
    input  logic [4:0]  fDestReg_in,
    input  logic [63:0] fbusW_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemWrite_in,
    input  logic        PCtoReg_in,
    input  logic        loadSign_in,
    input  logic        FPRegWrite_in,
    input  logic [1:0]  DSize_in,
    input  logic        ex_stall_in,
    mem_stage_if.master dmem,
    output logic [31:0] memData_out,
    output logic [31:0] aluResult_out,
    output logic [31:0] nextPC_out,
    output logic [4:0]  destReg_out,
    output logic [4:0]  fDestReg_out,
    output logic [63:0] fbusW_out,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic        PCtoReg_out,
    output logic        FPRegWrite_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    ex_mem_t         ex_mem_q, ex_mem_d;
    mem_wb_t         mem_wb_q, mem_wb_d;
    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic        mem_op, misaligned, access, abort, stall;
    logic [1:0]  offset;
    logic [31:0] load_data;

    assign offset     = ex_mem_q.alu_result[1:0];
    assign mem_op     = ex_mem_q.ctrl.mem_to_reg | ex_mem_q.ctrl.mem_write;
    assign misaligned = is_misaligned(ex_mem_q.size, offset);
    assign access     = mem_op & ~misaligned;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so all registers sample
    // their pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (stall)  state_d = S_WAIT;
            S_WAIT:  if (!stall) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // wait_cnt_q counts request cycles already spent, so it is 0 in IDLE. An
    // unanswered request aborts on its TIMEOUT-th cycle.
    always_comb begin
        abort      = access & ~dmem.dmem_ready & (wait_cnt_q == CNT_LAST);
        stall      = access & ~dmem.dmem_ready & ~abort;
        wait_cnt_d = '0;
        if (stall)
            wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + CW'(1) : CW'(1);
    end

    // ---------------- Store steering / bus drive ----------------
    // The bus is driven only from the held EX/MEM latch, so it stays stable while waiting.
    always_comb begin
        dmem.dmem_req   = access;
        dmem.dmem_we    = access & ex_mem_q.ctrl.mem_write;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        dmem.dmem_be    = '0;
        if (access) begin
            dmem.dmem_addr = {ex_mem_q.alu_result[31:2], 2'b00};
            case (ex_mem_q.size)
                SZ_BYTE: begin
                    dmem.dmem_wdata = {4{ex_mem_q.mem_val[7:0]}};
                    dmem.dmem_be    = 4'b1000 >> offset;
                end
                SZ_HALF: begin
                    dmem.dmem_wdata = {2{ex_mem_q.mem_val[15:0]}};
                    dmem.dmem_be    = offset[1] ? 4'b0011 : 4'b1100;
                end
                default: begin
                    dmem.dmem_wdata = ex_mem_q.mem_val;
                    dmem.dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i  (dmem.dmem_rdata),
        .offset_i (offset),
        .size_i   (ex_mem_q.size),
        .sign_i   (ex_mem_q.ctrl.load_sign),
        .data_o   (load_data)
    );

    // ---------------- EX/MEM latch ----------------
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!stall) begin
            ex_mem_d.alu_result        = aluResult_in;
            ex_mem_d.mem_val           = memVal_in;
            ex_mem_d.next_pc           = nextPC_in;
            ex_mem_d.dest_reg          = destReg_in;
            ex_mem_d.f_dest_reg        = fDestReg_in;
            ex_mem_d.fbus_w            = fbusW_in;
            ex_mem_d.size              = dsize_t'(DSize_in);
            ex_mem_d.ctrl.reg_write    = RegWrite_in;
            ex_mem_d.ctrl.mem_to_reg   = MemToReg_in;
            ex_mem_d.ctrl.mem_write    = MemWrite_in;
            ex_mem_d.ctrl.pc_to_reg    = PCtoReg_in;
            ex_mem_d.ctrl.load_sign    = loadSign_in;
            ex_mem_d.ctrl.fp_reg_write = FPRegWrite_in;
            if (ex_stall_in)
                ex_mem_d.ctrl = CTRL_BUBBLE;
        end
    end

    // ---------------- MEM/WB latch ----------------
    // A faulted op (misaligned or aborted) still reaches WB but must not write
    // registers. While stalled, WB sees a bubble so a held op is written once.
    always_comb begin
        mem_wb_d.mem_data     = load_data;
        mem_wb_d.alu_result   = ex_mem_q.alu_result;
        mem_wb_d.next_pc      = ex_mem_q.next_pc;
        mem_wb_d.dest_reg     = ex_mem_q.dest_reg;
        mem_wb_d.f_dest_reg   = ex_mem_q.f_dest_reg;
        mem_wb_d.fbus_w       = ex_mem_q.fbus_w;
        mem_wb_d.reg_write    = ex_mem_q.ctrl.reg_write    & ~misalign_out & ~abort;
        mem_wb_d.fp_reg_write = ex_mem_q.ctrl.fp_reg_write & ~misalign_out & ~abort;
        mem_wb_d.mem_to_reg   = ex_mem_q.ctrl.mem_to_reg;
        mem_wb_d.pc_to_reg    = ex_mem_q.ctrl.pc_to_reg;
        if (stall) begin
            mem_wb_d.reg_write    = 1'b0;
            mem_wb_d.fp_reg_write = 1'b0;
            mem_wb_d.mem_to_reg   = 1'b0;
            mem_wb_d.pc_to_reg    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign stall_out      = stall;
    assign misalign_out   = mem_op & misaligned;
    assign bus_err_out    = abort;

    assign memData_out    = mem_wb_q.mem_data;
    assign aluResult_out  = mem_wb_q.alu_result;
    assign nextPC_out     = mem_wb_q.next_pc;
    assign destReg_out    = mem_wb_q.dest_reg;
    assign fDestReg_out   = mem_wb_q.f_dest_reg;
    assign fbusW_out      = mem_wb_q.fbus_w;
    assign RegWrite_out   = mem_wb_q.reg_write;
    assign MemToReg_out   = mem_wb_q.mem_to_reg;
    assign PCtoReg_out    = mem_wb_q.pc_to_reg;
    assign FPRegWrite_out = mem_wb_q.fp_reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=4). Inputs change 1 ns after the
// rising edge and outputs are sampled there, away from the active edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluResult_in, memVal_in, nextPC_in;
    logic [4:0]  destReg_in, fDestReg_in;
    logic [63:0] fbusW_in;
    logic        RegWrite_in, MemToReg_in, MemWrite_in, PCtoReg_in, loadSign_in, FPRegWrite_in;
    logic [1:0]  DSize_in;
    logic        ex_stall_in;
    logic [31:0] memData_out, aluResult_out, nextPC_out;
    logic [4:0]  destReg_out, fDestReg_out;
    logic [63:0] fbusW_out;
    logic        RegWrite_out, MemToReg_out, PCtoReg_out, FPRegWrite_out;
    logic        stall_out, misalign_out, bus_err_out;

    int n_vec  = 0;
    int n_miss = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .aluResult_in(aluResult_in), .memVal_in(memVal_in), .nextPC_in(nextPC_in),
        .destReg_in(destReg_in), .fDestReg_in(fDestReg_in), .fbusW_in(fbusW_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .MemWrite_in(MemWrite_in),
        .PCtoReg_in(PCtoReg_in), .loadSign_in(loadSign_in), .FPRegWrite_in(FPRegWrite_in),
        .DSize_in(DSize_in), .ex_stall_in(ex_stall_in),
        .dmem(dmem_bus),
        .memData_out(memData_out), .aluResult_out(aluResult_out), .nextPC_out(nextPC_out),
        .destReg_out(destReg_out), .fDestReg_out(fDestReg_out), .fbusW_out(fbusW_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .PCtoReg_out(PCtoReg_out),
        .FPRegWrite_out(FPRegWrite_out), .stall_out(stall_out),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        aluResult_in = '0; memVal_in = '0; nextPC_in = '0; destReg_in = '0;
        fDestReg_in = '0; fbusW_in = '0; DSize_in = 2'b00; ex_stall_in = 1'b0;
        RegWrite_in = 1'b0; MemToReg_in = 1'b0; MemWrite_in = 1'b0;
        PCtoReg_in = 1'b0; loadSign_in = 1'b0; FPRegWrite_in = 1'b0;
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] mval, input logic [4:0] dest,
                          input logic [1:0] size, input logic rw, input logic mtr,
                          input logic mw, input logic ls);
        set_nop();
        aluResult_in = alu; memVal_in = mval; destReg_in = dest; DSize_in = size;
        RegWrite_in = rw; MemToReg_in = mtr; MemWrite_in = mw; loadSign_in = ls;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_nop();
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;
        step(); step();
        n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL rst_regwrite: got %b want 0", RegWrite_out); end
        n_vec++; if (memData_out !== 32'h0) begin n_miss++; $display("FAIL rst_memdata: got %h want 0", memData_out); end
        n_vec++; if (dmem_bus.dmem_req !== 1'b0) begin n_miss++; $display("FAIL rst_req: got %b want 0", dmem_bus.dmem_req); end
        n_vec++; if (dmem_bus.dmem_be !== 4'b0000) begin n_miss++; $display("FAIL rst_be: got %b want 0000", dmem_bus.dmem_be); end
        n_vec++; if (stall_out !== 1'b0) begin n_miss++; $display("FAIL rst_stall: got %b want 0", stall_out); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_load_byte();
        set_op(32'h0000_1003, 32'h0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h1122_3380;
        step();
        set_nop();
        n_vec++; if (dmem_bus.dmem_req !== 1'b1) begin n_miss++; $display("FAIL lb_req: got %b want 1", dmem_bus.dmem_req); end
        n_vec++; if (dmem_bus.dmem_be !== 4'b0001) begin n_miss++; $display("FAIL lb_be: got %b want 0001", dmem_bus.dmem_be); end
        n_vec++; if (dmem_bus.dmem_we !== 1'b0) begin n_miss++; $display("FAIL lb_we: got %b want 0", dmem_bus.dmem_we); end
        n_vec++; if (dmem_bus.dmem_addr !== 32'h0000_1000) begin n_miss++; $display("FAIL lb_addr: got %h want 00001000", dmem_bus.dmem_addr); end
        n_vec++; if (stall_out !== 1'b0) begin n_miss++; $display("FAIL lb_stall: got %b want 0", stall_out); end
        step();
        n_vec++; if (memData_out !== 32'hFFFF_FF80) begin n_miss++; $display("FAIL lb_data: got %h want ffffff80", memData_out); end
        n_vec++; if (RegWrite_out !== 1'b1) begin n_miss++; $display("FAIL lb_regwrite: got %b want 1", RegWrite_out); end
        n_vec++; if (destReg_out !== 5'd5) begin n_miss++; $display("FAIL lb_dest: got %0d want 5", destReg_out); end
    endtask

    task automatic test_load_lanes();
        logic [31:0] addr_v [4] = '{32'h5002, 32'h5000, 32'h5001, 32'h5004};
        logic [1:0]  size_v [4] = '{2'b01, 2'b01, 2'b00, 2'b10};
        logic        sign_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] rd_v   [4] = '{32'h1234_F00D, 32'h8001_0000, 32'h00A5_0000, 32'h89AB_CDEF};
        logic [31:0] exp_v  [4] = '{32'h0000_F00D, 32'hFFFF_8001, 32'h0000_00A5, 32'h89AB_CDEF};
        logic [3:0]  be_v   [4] = '{4'b0011, 4'b1100, 4'b0100, 4'b1111};
        dmem_bus.dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(addr_v[i], 32'h0, 5'd1, size_v[i], 1'b1, 1'b1, 1'b0, sign_v[i]);
            dmem_bus.dmem_rdata = rd_v[i];
            step();
            set_nop();
            n_vec++; if (dmem_bus.dmem_be !== be_v[i]) begin n_miss++; $display("FAIL ld%0d_be: got %b want %b", i, dmem_bus.dmem_be, be_v[i]); end
            step();
            n_vec++; if (memData_out !== exp_v[i]) begin n_miss++; $display("FAIL ld%0d_data: got %h want %h", i, memData_out, exp_v[i]); end
        end
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_stores();
        logic [31:0] addr_v [3] = '{32'h2002, 32'h7001, 32'h7008};
        logic [1:0]  size_v [3] = '{2'b01, 2'b00, 2'b10};
        logic [31:0] mv_v   [3] = '{32'h0000_ABCD, 32'h1234_565A, 32'hCAFE_F00D};
        logic [31:0] wd_v   [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_F00D};
        logic [3:0]  be_v   [3] = '{4'b0011, 4'b0100, 4'b1111};
        dmem_bus.dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(addr_v[i], mv_v[i], 5'd0, size_v[i], 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            set_nop();
            n_vec++; if (dmem_bus.dmem_wdata !== wd_v[i]) begin n_miss++; $display("FAIL st%0d_wdata: got %h want %h", i, dmem_bus.dmem_wdata, wd_v[i]); end
            n_vec++; if (dmem_bus.dmem_be !== be_v[i]) begin n_miss++; $display("FAIL st%0d_be: got %b want %b", i, dmem_bus.dmem_be, be_v[i]); end
            n_vec++; if (dmem_bus.dmem_we !== 1'b1) begin n_miss++; $display("FAIL st%0d_we: got %b want 1", i, dmem_bus.dmem_we); end
            step();
            n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL st%0d_regwrite: got %b want 0", i, RegWrite_out); end
        end
        dmem_bus.dmem_ready = 1'b0;
    endtask

    task automatic test_wait_states();
        set_op(32'h0000_3000, 32'h0, 5'd7, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b0;
        step();
        // Next instruction waits at the EX outputs while MEM is stalled.
        set_op(32'h0000_0055, 32'h0, 5'd9, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (stall_out !== 1'b1) begin n_miss++; $display("FAIL wt%0d_stall: got %b want 1", i, stall_out); end
            n_vec++; if (dmem_bus.dmem_addr !== 32'h3000 || dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_be !== 4'b1111)
                begin n_miss++; $display("FAIL wt%0d_bus: got addr %h req %b be %b want 00003000 1 1111", i, dmem_bus.dmem_addr, dmem_bus.dmem_req, dmem_bus.dmem_be); end
            if (i > 0) begin
                n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL wt%0d_bubble: got %b want 0", i, RegWrite_out); end
            end
            step();
        end
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (stall_out !== 1'b0) begin n_miss++; $display("FAIL wt_done_stall: got %b want 0", stall_out); end
        n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL wt_last_bubble: got %b want 0", RegWrite_out); end
        step();
        dmem_bus.dmem_ready = 1'b0;
        set_nop();
        n_vec++; if (memData_out !== 32'hDEAD_BEEF || RegWrite_out !== 1'b1 || destReg_out !== 5'd7)
            begin n_miss++; $display("FAIL wt_result: got %h %b %0d want deadbeef 1 7", memData_out, RegWrite_out, destReg_out); end
        n_vec++; if (dmem_bus.dmem_req !== 1'b0) begin n_miss++; $display("FAIL wt_next_req: got %b want 0", dmem_bus.dmem_req); end
        step();
        n_vec++; if (RegWrite_out !== 1'b1 || destReg_out !== 5'd9 || aluResult_out !== 32'h55)
            begin n_miss++; $display("FAIL wt_held_op: got %b %0d %h want 1 9 00000055", RegWrite_out, destReg_out, aluResult_out); end
    endtask

    task automatic test_timeout();
        set_op(32'h0000_4000, 32'h0, 5'd3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b0;
        step();
        set_nop();
        ex_stall_in = 1'b1;   // must not displace the held op
        for (int i = 1; i <= 3; i++) begin
            n_vec++; if (dmem_bus.dmem_req !== 1'b1 || stall_out !== 1'b1 || bus_err_out !== 1'b0)
                begin n_miss++; $display("FAIL to_cyc%0d: got req %b stall %b err %b want 1 1 0", i, dmem_bus.dmem_req, stall_out, bus_err_out); end
            step();
        end
        n_vec++; if (bus_err_out !== 1'b1 || stall_out !== 1'b0 || dmem_bus.dmem_req !== 1'b1)
            begin n_miss++; $display("FAIL to_abort: got err %b stall %b req %b want 1 0 1", bus_err_out, stall_out, dmem_bus.dmem_req); end
        ex_stall_in = 1'b0;
        step();
        n_vec++; if (bus_err_out !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin n_miss++; $display("FAIL to_after: got err %b req %b want 0 0", bus_err_out, dmem_bus.dmem_req); end
        n_vec++; if (RegWrite_out !== 1'b0 || destReg_out !== 5'd3) begin n_miss++; $display("FAIL to_wb: got %b %0d want 0 3", RegWrite_out, destReg_out); end
        // A fresh request must start its wait count from zero.
        set_op(32'h0000_4010, 32'h0, 5'd3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_nop();
        n_vec++; if (stall_out !== 1'b1 || bus_err_out !== 1'b0) begin n_miss++; $display("FAIL to_restart: got stall %b err %b want 1 0", stall_out, bus_err_out); end
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h0BAD_F00D;
        step();
        dmem_bus.dmem_ready = 1'b0;
        n_vec++; if (memData_out !== 32'h0BAD_F00D || RegWrite_out !== 1'b1)
            begin n_miss++; $display("FAIL to_restart_wb: got %h %b want 0badf00d 1", memData_out, RegWrite_out); end
    endtask

    task automatic test_misalign();
        set_op(32'h0000_0006, 32'h0, 5'd4, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_nop();
        n_vec++; if (dmem_bus.dmem_req !== 1'b0 || misalign_out !== 1'b1 || stall_out !== 1'b0)
            begin n_miss++; $display("FAIL mw_detect: got req %b mis %b stall %b want 0 1 0", dmem_bus.dmem_req, misalign_out, stall_out); end
        step();
        n_vec++; if (misalign_out !== 1'b0) begin n_miss++; $display("FAIL mw_pulse: got %b want 0", misalign_out); end
        n_vec++; if (RegWrite_out !== 1'b0 || destReg_out !== 5'd4 || MemToReg_out !== 1'b1)
            begin n_miss++; $display("FAIL mw_wb: got %b %0d %b want 0 4 1", RegWrite_out, destReg_out, MemToReg_out); end
        set_op(32'h0000_0101, 32'h0, 5'd4, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_nop();
        n_vec++; if (dmem_bus.dmem_req !== 1'b0 || misalign_out !== 1'b1)
            begin n_miss++; $display("FAIL mh_detect: got req %b mis %b want 0 1", dmem_bus.dmem_req, misalign_out); end
        step();
    endtask

    task automatic test_ex_stall();
        set_op(32'h0000_0777, 32'h0, 5'd10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        ex_stall_in = 1'b1;
        step();
        step();
        n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL es_bubble1: got %b want 0", RegWrite_out); end
        ex_stall_in = 1'b0;
        step();
        set_nop();
        n_vec++; if (RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL es_bubble2: got %b want 0", RegWrite_out); end
        step();
        n_vec++; if (RegWrite_out !== 1'b1 || destReg_out !== 5'd10 || aluResult_out !== 32'h777)
            begin n_miss++; $display("FAIL es_op: got %b %0d %h want 1 10 00000777", RegWrite_out, destReg_out, aluResult_out); end
    endtask

    task automatic test_passthrough();
        set_op(32'h1234_5678, 32'h0, 5'd11, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        nextPC_in = 32'h0000_0104; PCtoReg_in = 1'b1; fDestReg_in = 5'd2;
        fbusW_in = 64'h0123_4567_89AB_CDEF; FPRegWrite_in = 1'b1;
        step();
        set_nop();
        n_vec++; if (RegWrite_out !== 1'b0 || destReg_out === 5'd11) begin n_miss++; $display("FAIL pt_latency: got %b %0d want 0 and dest not 11", RegWrite_out, destReg_out); end
        step();
        n_vec++; if (aluResult_out !== 32'h1234_5678 || nextPC_out !== 32'h104 || PCtoReg_out !== 1'b1)
            begin n_miss++; $display("FAIL pt_int: got %h %h %b want 12345678 00000104 1", aluResult_out, nextPC_out, PCtoReg_out); end
        n_vec++; if (fbusW_out !== 64'h0123_4567_89AB_CDEF || fDestReg_out !== 5'd2 || FPRegWrite_out !== 1'b1)
            begin n_miss++; $display("FAIL pt_fp: got %h %0d %b want 0123456789abcdef 2 1", fbusW_out, fDestReg_out, FPRegWrite_out); end
    endtask

    task automatic test_reset_mid_wait();
        set_op(32'h0000_8000, 32'h0, 5'd6, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b0;
        step();
        set_nop();
        n_vec++; if (dmem_bus.dmem_req !== 1'b1) begin n_miss++; $display("FAIL rw_req: got %b want 1", dmem_bus.dmem_req); end
        step();
        reset = 1'b0;
        #1;
        n_vec++; if (dmem_bus.dmem_req !== 1'b0 || stall_out !== 1'b0 || dmem_bus.dmem_addr !== 32'h0 || dmem_bus.dmem_be !== 4'h0)
            begin n_miss++; $display("FAIL rw_bus: got req %b stall %b addr %h be %b want all 0", dmem_bus.dmem_req, stall_out, dmem_bus.dmem_addr, dmem_bus.dmem_be); end
        n_vec++; if (aluResult_out !== 32'h0 || RegWrite_out !== 1'b0) begin n_miss++; $display("FAIL rw_wb: got %h %b want 0 0", aluResult_out, RegWrite_out); end
        step();
        reset = 1'b1;
        dmem_bus.dmem_ready = 1'b1;   // no request outstanding: ready must be ignored
        step();
        n_vec++; if (dmem_bus.dmem_req !== 1'b0 || stall_out !== 1'b0 || RegWrite_out !== 1'b0)
            begin n_miss++; $display("FAIL rw_idle_ready: got req %b stall %b rw %b want 0 0 0", dmem_bus.dmem_req, stall_out, RegWrite_out); end
        dmem_bus.dmem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_lanes();
        test_stores();
        test_wait_states();
        test_timeout();
        test_misalign();
        test_ex_stall();
        test_passthrough();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Latches EX results into an internal EX/MEM register and performs data-memory loads and stores over a req/ready handshake.
- Load data is byte-lane aligned and extended; stores are lane-steered with byte enables.
- Presents a registered MEM/WB bundle to writeback and raises a stall while a memory access is outstanding.

Parameters:
TIMEOUT, 16, max cycles dmem_req may stay unanswered before the access is aborted with bus_err_out (TIMEOUT >= 1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
aluResult_in  in  32  EX ALU result / effective address
memVal_in  in  32  store data from EX
nextPC_in  in  32  PC+4 from EX
destReg_in  in  5  integer destination register
fDestReg_in  in  5  FP destination register
fbusW_in  in  64  FP write data from EX
RegWrite_in, MemToReg_in, MemWrite_in, PCtoReg_in, loadSign_in, FPRegWrite_in  in  1 each  EX control
DSize_in  in  2  access size: 00 byte, 01 half, 10 word, 11 word
ex_stall_in  in  1  EX stall (multiplier busy)
dmem_addr  out  32  word-aligned address (bits [30:31] = 0)
dmem_wdata  out  32  lane-steered store data
dmem_be  out  4  byte enables, bit 0 = bits [0:7]
dmem_req, dmem_we  out  1  request, write strobe
dmem_rdata  in  32  read data
dmem_ready  in  1  access complete
memData_out, aluResult_out, nextPC_out  out  32  registered WB data
destReg_out, fDestReg_out  out  5  registered destinations
fbusW_out  out  64  registered FP data
RegWrite_out, MemToReg_out, PCtoReg_out, FPRegWrite_out  out  1  registered WB control
stall_out  out  1  freeze upstream stages
misalign_out, bus_err_out  out  1  one-cycle exception pulses

Behaviour:
- Endianness: big-endian. Address offset 0 maps to bits [0:7].
- Reset (reset=0, asynchronous): both latches cleared, all control bits 0, data 0, FSM to IDLE, wait counter 0, all outputs 0.
- EX/MEM latch:
  - stall_out=1: holds its contents.
  - else ex_stall_in=1: loads a bubble (all write and enable controls 0).
  - else: loads the EX inputs.
- Memory op definition: MemToReg or MemWrite set in the EX/MEM latch.
- Misalignment: half with addr[31]=1, or word with addr[30:31]!=0.
  - Misaligned op issues no request.
  - misalign_out pulses for one cycle.
  - WB latch receives the op with RegWrite and FPRegWrite forced to 0.
- Timing: non-memory ops take one cycle in the stage, giving 2-cycle total register latency from EX outputs to WB outputs.
- FSM states: IDLE, WAIT.
  - IDLE, aligned memory op in latch: dmem_req=1 combinationally.
    - dmem_ready=1 in the same cycle: op completes, stall_out=0.
    - otherwise: go to WAIT, stall_out=1.
  - WAIT: dmem_req and all dmem outputs are held stable, stall_out=1, counter increments.
    - dmem_ready=1: complete, stall_out=0 that cycle, return to IDLE.
    - counter reaches TIMEOUT-1 without ready: abort, bus_err_out pulses, op goes to WB with RegWrite=0, return to IDLE.
- stall_out = (memory op in latch) & ~dmem_ready & ~abort.
- Store: dmem_we=1.
  - Byte: data replicated in all lanes, be = one-hot of addr[30:31].
  - Half: data replicated in both halves, be = 1100 or 0011.
  - Word: be = 1111.
- Load: dmem_we=0, be per size.
  - Selected lane is right-justified.
  - Sign-extended if loadSign=1, else zero-extended.
  - Result goes to memData_out.
- MEM/WB latch:
  - Loads a bubble whenever stall_out=1, so WB never writes twice.
  - Otherwise loads the completed op.
- dmem_ready while not requesting is ignored.
- ex_stall_in and stall_out both high: stall_out dominates.
- Reset mid-WAIT: access is dropped and dmem_req deasserts immediately.

Decomposition:
- Shared package:
  - DSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state encoding
  - Bubble control constant
- One sub-module: load_align, a combinational lane select plus sign/zero extend over (rdata, addr[30:31], DSize, loadSign).
- Store steering stays inline.

Test Plan:
- Load byte, not stalled: addr=0x1003, loadSign=1, rdata=0x1122_3380, ready same cycle -> memData_out=0xFFFF_FF80, be=0001, no stall.
- Store half, not stalled: addr=0x2002, memVal=0x0000_ABCD -> wdata=0xABCD_ABCD, be=0011, we=1, RegWrite_out=0.
- ready held low 3 cycles on a word load -> stall_out=1 for exactly 3 cycles, dmem outputs stable, one WB result, bubbles in between.
- TIMEOUT=4, ready never asserted -> bus_err_out pulse after 4 request cycles, RegWrite_out=0, FSM in IDLE.
- Word load at addr=0x0000_0006 -> no dmem_req, misalign_out pulse, RegWrite_out=0.
- ex_stall_in=1 for 2 cycles with ALU op -> 2 bubbles at WB outputs. Reset asserted during WAIT -> all outputs 0 immediately.
